// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported SRAM between NUM_REQ masters with
// round-robin arbitration, bounded burst lock and read-response routing. Rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]         mem_be_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [IDX_W:0]   NUM_W   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_ID = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  logic [IDX_W-1:0] prio_q;
  logic             last_valid_q;
  logic [IDX_W-1:0] last_q;
  logic             last_lock_q;
  logic [CNT_W-1:0] lock_cnt_q;

  logic [MEM_LATENCY-1:0]            valid_pipe_q;
  logic [MEM_LATENCY-1:0][IDX_W-1:0] idx_pipe_q;

  logic             lock_hit;
  logic             found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   cand;
  logic [NUM_REQ-1:0] gnt;

  // A lock only survives while its owner keeps requesting and the burst budget remains.
  assign lock_hit = last_valid_q && last_lock_q && req_i[last_q] && (lock_cnt_q < MAX_CNT);

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, prio_q} + (IDX_W + 1)'(i);
      if (cand >= NUM_W) cand = cand - NUM_W;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (lock_hit) begin
      found   = 1'b1;
      gnt_idx = last_q;
    end
  end

  assign gnt   = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign gnt_o = gnt;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_be_o    = be_i[i*BE_W +: BE_W];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_req_o = found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q       <= '0;
      last_valid_q <= 1'b0;
      last_q       <= '0;
      last_lock_q  <= 1'b0;
      lock_cnt_q   <= '0;
    end else if (found) begin
      prio_q       <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
      last_valid_q <= 1'b1;
      last_q       <= gnt_idx;
      last_lock_q  <= lock_i[gnt_idx];
      lock_cnt_q   <= lock_hit ? lock_cnt_q + 1'b1 : '0;
    end else begin
      last_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
    end
  end

  // Read tags travel alongside the SRAM latency so the response lands on its issuer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_pipe_q <= '0;
      idx_pipe_q   <= '0;
    end else begin
      valid_pipe_q[0] <= found && !mem_we_o;
      idx_pipe_q[0]   <= gnt_idx;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        valid_pipe_q[i] <= valid_pipe_q[i-1];
        idx_pipe_q[i]   <= idx_pipe_q[i-1];
      end
    end
  end

  assign rvalid_o = valid_pipe_q[MEM_LATENCY-1] ? (NUM_REQ'(1) << idx_pipe_q[MEM_LATENCY-1]) : '0;
  assign rdata_o  = mem_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for lock, latency and reset.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [1:0]    req_i, lock_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [15:0]   be_i;
  logic [2*DW-1:0] wdata_i;
  logic [DW-1:0] mem_rdata_i;

  logic [1:0]    gnt1, rvalid1, gnt3, rvalid3;
  logic [DW-1:0] rdata1, rdata3, mwdata1, mwdata3;
  logic          mreq1, mwe1, mreq3, mwe3;
  logic [AW-1:0] maddr1, maddr3;
  logic [7:0]    mbe1, mbe3;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [AW-1:0] A0 = 64'h100, A1 = 64'h40;
  localparam logic [DW-1:0] D0 = 64'h1111, D1 = 64'hDEAD;
  localparam logic [7:0]    B0 = 8'h0F,   B1 = 8'hFF;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .MAX_LOCK(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1),
    .mem_be_o(mbe1), .mem_wdata_o(mwdata1), .mem_rdata_i(mem_rdata_i));

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .MAX_LOCK(16)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3),
    .mem_be_o(mbe3), .mem_wdata_o(mwdata3), .mem_rdata_i(mem_rdata_i));

  typedef struct {
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] we;
    logic [1:0] gnt;
    logic [1:0] rvalid;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req_i  = '0; lock_i = '0; we_i = '0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    addr_i      = {A1, A0};
    wdata_i     = {D1, D0};
    be_i        = {B1, B0};
    mem_rdata_i = '0;

    //            req    lock   we     gnt    rvalid
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01};
    tbl[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[5]  = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    tbl[9]  = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[11] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[14] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00};
    tbl[15] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    do_reset();
    #2;
    check("reset_gnt", 64'(gnt1), 64'd0);
    check("reset_rvalid", 64'(rvalid1), 64'd0);
    check("reset_mem_req", 64'(mreq1), 64'd0);
    check("reset_mem_addr", maddr1, 64'd0);

    for (int n = 0; n < 17; n++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [7:0]    eb;
      @(negedge clk_i);
      req_i = tbl[n].req; lock_i = tbl[n].lock; we_i = tbl[n].we;
      mem_rdata_i = 64'hA000 + 64'(n);
      ea = tbl[n].gnt[0] ? A0 : (tbl[n].gnt[1] ? A1 : '0);
      ed = tbl[n].gnt[0] ? D0 : (tbl[n].gnt[1] ? D1 : '0);
      eb = tbl[n].gnt[0] ? B0 : (tbl[n].gnt[1] ? B1 : '0);
      #2;
      check($sformatf("v%0d_gnt", n), 64'(gnt1), 64'(tbl[n].gnt));
      check($sformatf("v%0d_rvalid", n), 64'(rvalid1), 64'(tbl[n].rvalid));
      check($sformatf("v%0d_mem_req", n), 64'(mreq1), 64'(|tbl[n].gnt));
      check($sformatf("v%0d_mem_we", n), 64'(mwe1), 64'(|(tbl[n].gnt & tbl[n].we)));
      check($sformatf("v%0d_mem_addr", n), maddr1, ea);
      check($sformatf("v%0d_mem_wdata", n), mwdata1, ed);
      check($sformatf("v%0d_mem_be", n), 64'(mbe1), 64'(eb));
      check($sformatf("v%0d_rdata", n), rdata1, 64'hA000 + 64'(n));
    end

    // Starvation guard: 1 unlocked + 16 locked grants to req 0, one to req 1, then relock.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      req_i = 2'b11; lock_i = 2'b01; we_i = 2'b00;
      #2;
      check($sformatf("lock_c%0d_gnt", c), 64'(gnt1), (c == 17) ? 64'd2 : 64'd1);
    end

    // MEM_LATENCY=3: reads 0,1,0 return on cycles +3,+4,+5.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic [1:0] exp_rv;
      @(negedge clk_i);
      lock_i = 2'b00; we_i = 2'b00;
      req_i = (c == 0 || c == 2) ? 2'b01 : (c == 1 ? 2'b10 : 2'b00);
      mem_rdata_i = 64'hC0 + 64'(c);
      exp_rv = (c == 3 || c == 5) ? 2'b01 : (c == 4 ? 2'b10 : 2'b00);
      #2;
      check($sformatf("lat3_c%0d_rvalid", c), 64'(rvalid3), 64'(exp_rv));
      check($sformatf("lat3_c%0d_rdata", c), rdata3, 64'hC0 + 64'(c));
    end

    // Reset pulse while reads are in flight.
    do_reset();
    @(negedge clk_i);
    req_i = 2'b01; lock_i = 2'b00; we_i = 2'b00;
    #2;
    check("midrst_gnt", 64'(gnt1), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 2'b10;
    #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    req_i = 2'b00;
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("midrst_c%0d_rvalid1", c), 64'(rvalid1), 64'd0);
      check($sformatf("midrst_c%0d_rvalid3", c), 64'(rvalid3), 64'd0);
      @(negedge clk_i);
    end
    req_i = 2'b11;
    #2;
    check("midrst_prio_gnt1", 64'(gnt1), 64'd1);
    check("midrst_prio_gnt3", 64'(gnt3), 64'd1);
    @(negedge clk_i);
    req_i = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
